seg_counter_n: RTL and testbench

Parametrised N-digit BCD up/down counter with built-in tick prescaler, synchronous load, wrap pulse and per-digit 7-segment decode. It succeeds the single-digit 1 Hz segment counter in the display path. It is clocked from the system clock rather than a 1 Hz clock, and generates its own count tick internally. All digits are presented in parallel on one packed segment bus for the board display driver.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg7_decode.sv | 11 +
 rtl/seg_counter_n.sv | 113 +++++++++++
 tb/tb_seg_counter_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared digit type, 7-segment patterns and prescaler divide helper for seg_counter_n.
package seg_pkg;
  typedef logic [3:0] digit_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Index is the BCD digit; bits {dp,g,f,e,d,c,b,a}. Codes 10..15 decode as blank.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one BCD digit to active-high segments {dp,g,f,e,d,c,b,a}, with blank override.
// Purely combinational, zero latency; no flow control.
module seg7_decode
  import seg_pkg::*;
(
  input  digit_t     digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);
  assign seg_o = blank_i ? SEG_BLANK : SEG_LUT[digit_i];
endmodule

// File: rtl/seg_counter_n.sv
// seg_counter_n: N-digit BCD up/down counter with internal tick prescaler, clamped load, wrap pulse and
// per-digit 7-seg decode; bcd/wrap update one cycle after tick or load, seg is combinational. SEG_LZB_EN enables leading-zero blanking.
module seg_counter_n
  import seg_pkg::*;
#(
  parameter int DIGITS  = 3,
  parameter int CLK_HZ  = 1,
  parameter int TICK_HZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap,
  output logic [8*DIGITS-1:0]   seg
);
  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0]       pcnt_q, pcnt_d;
  digit_t [DIGITS-1:0] bcd_q, bcd_d, step_val, load_clamp;
  logic                wrap_q, wrap_d;
  logic                carry;
  logic [DIGITS-1:0]   blank;

  assign tick = en & (pcnt_q == PMAX);

  // Ripple one step through the digits; carry surviving past the top digit means full-range wrap.
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      step_val[i]   = bcd_q[i];
      load_clamp[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      if (carry) begin
        if (up_dn) begin
          if (bcd_q[i] == 4'd9) begin
            step_val[i] = 4'd0;
          end else begin
            step_val[i] = bcd_q[i] + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (bcd_q[i] == 4'd0) begin
            step_val[i] = 4'd9;
          end else begin
            step_val[i] = bcd_q[i] - 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (load) begin
      pcnt_d = '0;
      bcd_d  = load_clamp;
    end else if (en) begin
      pcnt_d = tick ? '0 : pcnt_q + PW'(1);
      if (tick) begin
        bcd_d  = step_val;
        wrap_d = carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef SEG_LZB_EN
  logic nz_seen;

  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    nz_seen = 1'b0;
    blank   = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz_seen  = nz_seen | (bcd_q[i] != 4'd0);
      blank[i] = ~nz_seen;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit_i (bcd_q[g]),
      .blank_i (blank[g]),
      .seg_o   (seg[8*g +: 8])
    );
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_seg_counter_n.sv
// Bench for seg_counter_n (DIGITS=3, DIV=4): directed vector table, hand sequences, random vs integer model.
module tb_seg_counter_n;
  localparam int DIGITS = 3, CLK_HZ = 4, TICK_HZ = 1, DIV = 4, MAXV = 999;
`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0;
  logic [11:0] load_val = '0;
  logic        tick, wrap;
  logic [11:0] bcd;
  logic [23:0] seg;

  int checks = 0, failures = 0;
  int mval = 0, mph = 0;
  bit mwrap = 1'b0;

  seg_counter_n #(.DIGITS(DIGITS), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .tick(tick), .bcd(bcd), .wrap(wrap), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ld;
    logic [11:0] lv;
    bit          en;
    bit          up;
    int          cyc;
    logic [11:0] ebcd;
    bit          ewrap;
    bit          etick;
    logic [23:0] eseg;
    logic [23:0] eseg_lzb;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F; 4: return 8'h66;
      5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07; 8: return 8'h7F; default: return 8'h6F;
    endcase
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int p;
    r = '0; p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [23:0] model_seg(input int v);
    logic [23:0] s;
    int p;
    s = '0; p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s[8*i +: 8] = (LZB && i > 0 && v < p) ? 8'h00 : pat((v / p) % 10);
      p = p * 10;
    end
    return s;
  endfunction

  function automatic int clamp_val(input logic [11:0] lv);
    int v, p, n;
    v = 0; p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_edge();
    mwrap = 1'b0;
    if (load) begin
      mval = clamp_val(load_val);
      mph  = 0;
    end else if (en) begin
      if (mph == DIV - 1) begin
        mph = 0;
        if (up_dn) begin
          if (mval == MAXV) begin mval = 0; mwrap = 1'b1; end
          else mval = mval + 1;
        end else begin
          if (mval == 0) begin mval = MAXV; mwrap = 1'b1; end
          else mval = mval - 1;
        end
      end else begin
        mph = mph + 1;
      end
    end
  endtask

  task automatic model_check();
    check("model_bcd", 32'(bcd), 32'(to_bcd(mval)));
    check("model_wrap", 32'(wrap), 32'(mwrap));
    check("model_tick", 32'(tick), 32'(en && (mph == DIV - 1)));
    check("model_seg", 32'(seg), 32'(model_seg(mval)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  initial begin
    //            ld  lv      en up cyc ebcd    ew et eseg        eseg_lzb
    tbl[0]  = '{0, 12'h000, 1, 1, 3, 12'h000, 0, 1, 24'h3F3F3F, 24'h00003F};
    tbl[1]  = '{0, 12'h000, 1, 1, 1, 12'h001, 0, 0, 24'h3F3F06, 24'h000006};
    tbl[2]  = '{1, 12'h998, 1, 1, 1, 12'h998, 0, 0, 24'h6F6F7F, 24'h6F6F7F};
    tbl[3]  = '{0, 12'h000, 1, 1, 4, 12'h999, 0, 0, 24'h6F6F6F, 24'h6F6F6F};
    tbl[4]  = '{0, 12'h000, 1, 1, 4, 12'h000, 1, 0, 24'h3F3F3F, 24'h00003F};
    tbl[5]  = '{0, 12'h000, 1, 1, 1, 12'h000, 0, 0, 24'h3F3F3F, 24'h00003F};
    tbl[6]  = '{0, 12'h000, 1, 0, 3, 12'h999, 1, 0, 24'h6F6F6F, 24'h6F6F6F};
    tbl[7]  = '{1, 12'h1A5, 1, 1, 1, 12'h195, 0, 0, 24'h066F6D, 24'h066F6D};
    tbl[8]  = '{0, 12'h000, 1, 1, 3, 12'h195, 0, 1, 24'h066F6D, 24'h066F6D};
    tbl[9]  = '{1, 12'h042, 1, 1, 1, 12'h042, 0, 0, 24'h3F665B, 24'h00665B};
    tbl[10] = '{0, 12'h000, 1, 1, 2, 12'h042, 0, 0, 24'h3F665B, 24'h00665B};

    #12;
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_seg", 32'(seg), LZB ? 32'h00003F : 32'h3F3F3F);
    rst = 1'b1;

    for (int v = 0; v < 11; v++) begin
      load = tbl[v].ld; load_val = tbl[v].lv; en = tbl[v].en; up_dn = tbl[v].up;
      for (int c = 0; c < tbl[v].cyc; c++) step();
      check("vec_bcd", 32'(bcd), 32'(tbl[v].ebcd));
      check("vec_wrap", 32'(wrap), 32'(tbl[v].ewrap));
      check("vec_tick", 32'(tick), 32'(tbl[v].etick));
      check("vec_seg", 32'(seg), LZB ? 32'(tbl[v].eseg_lzb) : 32'(tbl[v].eseg));
    end
    load = 1'b0;

    // Async reset in the middle of a period, no clock edge in between.
    #3 rst = 1'b0;
    #1;
    check("arst_bcd", 32'(bcd), 32'h0);
    check("arst_tick", 32'(tick), 32'h0);
    check("arst_wrap", 32'(wrap), 32'h0);
    check("arst_seg", 32'(seg), LZB ? 32'h00003F : 32'h3F3F3F);
    mval = 0; mph = 0; mwrap = 1'b0;
    #2 rst = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("arst_first_tick", 32'(tick), 32'h1);
    step();
    check("arst_first_inc", 32'(bcd), 32'h001);

    // Freeze with en=0 mid-period; remaining phase completes after resume.
    step(); step();
    en = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("hold_bcd", 32'(bcd), 32'h001);
    check("hold_tick", 32'(tick), 32'h0);
    en = 1'b1;
    step();
    check("resume_tick", 32'(tick), 32'h1);
    step();
    check("resume_bcd", 32'(bcd), 32'h002);

    for (int c = 0; c < 600; c++) begin
      en       = ($urandom % 8) != 0;
      up_dn    = $urandom % 2;
      load     = ($urandom % 20) == 0;
      load_val = 12'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
